aes_128_iter: RTL



---
 rtl/aes_128_iter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryptor: one round per clock through a shared round datapath,
// with the round key expanded on the fly alongside the cipher state.
package aes_128_iter_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

module sub_bytes
  import aes_128_iter_pkg::*;
(
  input  logic [127:0] in_bus,
  output logic [127:0] out_bus
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign out_bus[8*i +: 8] = sbox(in_bus[8*i +: 8]);
  end
endmodule

module shift_rows (
  input  logic [127:0] in_bus,
  output logic [127:0] out_bus
);
  // Byte 4c+r holds row r of column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign out_bus[127-8*(4*c+r) -: 8] = in_bus[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_columns
  import aes_128_iter_pkg::*;
(
  input  logic [127:0] in_bus,
  output logic [127:0] out_bus
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = in_bus[127-32*c -: 8];
    assign w_a1 = in_bus[119-32*c -: 8];
    assign w_a2 = in_bus[111-32*c -: 8];
    assign w_a3 = in_bus[103-32*c -: 8];
    assign out_bus[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign out_bus[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign out_bus[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign out_bus[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end
endmodule

// state | meaning
// IDLE  | ready for a job, in_ready = 1
// RUN   | one AES round per clock, rounds 1..10
// DONE  | ciphertext presented until out_ready
module aes_128_iter
  import aes_128_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [127:0] r_st, r_rk;
  logic [3:0]   r_rnd;
  logic [7:0]   r_rcon;

  logic [127:0] w_sb, w_sr, w_mc, w_round, w_nk;
  logic [31:0]  w_rot, w_sub, w_w3r;
  logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;

  sub_bytes   u_sub_bytes   (.in_bus(r_st), .out_bus(w_sb));
  shift_rows  u_shift_rows  (.in_bus(w_sb), .out_bus(w_sr));
  mix_columns u_mix_columns (.in_bus(w_sr), .out_bus(w_mc));

  assign w_round = (r_rnd == 4'd10) ? w_sr : w_mc;

  // Key schedule has its own 4-byte S-box so it runs in parallel with the state path.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_w3r = w_sub ^ {r_rcon, 24'h0};
  assign w_nk0 = r_rk[127:96] ^ w_w3r;
  assign w_nk1 = r_rk[95:64]  ^ w_nk0;
  assign w_nk2 = r_rk[63:32]  ^ w_nk1;
  assign w_nk3 = r_rk[31:0]   ^ w_nk2;
  assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)          w_state_nxt = S_RUN;
      S_RUN:   if (r_rnd == 4'd10)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= '0;
      r_rk   <= '0;
      r_rnd  <= '0;
      r_rcon <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_st   <= in_bus ^ key;
          r_rk   <= key;
          r_rnd  <= 4'd1;
          r_rcon <= 8'h01;
        end
        S_RUN: begin
          r_st   <= w_round ^ w_nk;
          r_rk   <= w_nk;
          r_rnd  <= r_rnd + 4'd1;
          r_rcon <= xtime(r_rcon);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_bus   = out_valid ? r_st : '0;
endmodule
